dsp19x2_mac_sequencer: RTL and testbench

Sequencer that owns one DSP19X2 instance configured as `DSP_MODE="MULTIPLY_ACCUMULATE"`. It accepts a dot-product job over a valid/ready command port and streams operand pairs into both multiplier lanes. It controls accumulator loading, drains the DSP pipeline, and returns the two 19-bit sums over a valid/ready result port. It sits between a stream producer (FIR/matrix engine) and the DSP primitive, so the producer never handles LOAD_ACC timing or pipeline depth.

---
 rtl/dsp19x2_seq_pkg.sv | 28 ++
 rtl/dsp19x2_op_stage.sv | 59 +++++
 rtl/dsp19x2_mac_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_dsp19x2_mac_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp19x2_seq_pkg.sv
// Shared types and widths for the DSP19X2 multiply-accumulate sequencer.
package dsp19x2_seq_pkg;

  // Operand, result and shift widths of the DSP19X2 in multiply-accumulate mode.
  localparam int A_W     = 10;
  localparam int B_W     = 9;
  localparam int Z_W     = 19;
  localparam int SHIFT_W = 5;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  // Per-job DSP configuration, latched at command acceptance.
  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic               round;
    logic               saturate;
    logic               subtract;
    logic               unsigned_a;
    logic               unsigned_b;
  } cfg_t;

endpackage

// File: rtl/dsp19x2_op_stage.sv
// Registered operand / LOAD_ACC stage feeding the DSP. A cycle without an
// accepted operand pair presents zeros, so the accumulator adds nothing.
module dsp19x2_op_stage
  import dsp19x2_seq_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET,
  input  logic           i_load,
  input  logic           i_first,
  input  logic [A_W-1:0] i_a1,
  input  logic [A_W-1:0] i_a2,
  input  logic [B_W-1:0] i_b1,
  input  logic [B_W-1:0] i_b2,
  output logic [A_W-1:0] o_dsp_a1,
  output logic [A_W-1:0] o_dsp_a2,
  output logic [B_W-1:0] o_dsp_b1,
  output logic [B_W-1:0] o_dsp_b2,
  output logic           o_dsp_load_acc
);

  logic [A_W-1:0] r_a1;
  logic [A_W-1:0] r_a2;
  logic [B_W-1:0] r_b1;
  logic [B_W-1:0] r_b2;
  logic           r_load_acc;

  // Present the accepted pair for one cycle, otherwise a zero bubble.
  // NOTE: reset is sampled on the clock edge (synchronous, active-low) and all
  // state updates use non-blocking assignments so every register sees the
  // pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_a1       <= '0;
      r_a2       <= '0;
      r_b1       <= '0;
      r_b2       <= '0;
      r_load_acc <= 1'b0;
    end else if (i_load) begin
      r_a1       <= i_a1;
      r_a2       <= i_a2;
      r_b1       <= i_b1;
      r_b2       <= i_b2;
      r_load_acc <= i_first;
    end else begin
      r_a1       <= '0;
      r_a2       <= '0;
      r_b1       <= '0;
      r_b2       <= '0;
      r_load_acc <= 1'b0;
    end
  end

  assign o_dsp_a1       = r_a1;
  assign o_dsp_a2       = r_a2;
  assign o_dsp_b1       = r_b1;
  assign o_dsp_b2       = r_b2;
  assign o_dsp_load_acc = r_load_acc;

endmodule

// File: rtl/dsp19x2_mac_sequencer.sv
// Dot-product job sequencer around one DSP19X2 in multiply-accumulate mode.
// Accepts a job, streams operand pairs into both lanes, waits out the DSP
// pipeline and returns both 19-bit sums over a valid/ready result port.
module dsp19x2_mac_sequencer
  import dsp19x2_seq_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int DSP_LATENCY = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  // Job command
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic               cmd_round,
  input  logic               cmd_saturate,
  input  logic               cmd_subtract,
  input  logic               cmd_unsigned_a,
  input  logic               cmd_unsigned_b,
  // Operand stream
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [A_W-1:0]     op_a1,
  input  logic [A_W-1:0]     op_a2,
  input  logic [B_W-1:0]     op_b1,
  input  logic [B_W-1:0]     op_b2,
  // Result
  output logic               res_valid,
  input  logic               res_ready,
  output logic [Z_W-1:0]     res_z1,
  output logic [Z_W-1:0]     res_z2,
  output logic               busy,
  // DSP19X2 side
  output logic [A_W-1:0]     dsp_a1,
  output logic [A_W-1:0]     dsp_a2,
  output logic [B_W-1:0]     dsp_b1,
  output logic [B_W-1:0]     dsp_b2,
  output logic               dsp_load_acc,
  output logic [2:0]         dsp_feedback,
  output logic [SHIFT_W-1:0] dsp_shift_right,
  output logic               dsp_round,
  output logic               dsp_saturate,
  output logic               dsp_subtract,
  output logic               dsp_unsigned_a,
  output logic               dsp_unsigned_b,
  input  logic [Z_W-1:0]     dsp_z1,
  input  logic [Z_W-1:0]     dsp_z2
);

  // Drain counter must hold DSP_LATENCY; keep at least one bit for latency 0.
  localparam int                 DRAIN_W    = (DSP_LATENCY < 1) ? 1 : $clog2(DSP_LATENCY + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DSP_LATENCY);

  state_t             r_state;
  logic [LEN_W-1:0]   r_remaining;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_first;
  cfg_t               r_cfg;
  logic               r_cmd_ready;
  logic               r_op_ready;
  logic               r_res_valid;
  logic               r_busy;
  logic [Z_W-1:0]     r_res_z1;
  logic [Z_W-1:0]     r_res_z2;

  logic               w_cmd_hs;
  logic               w_op_hs;
  logic               w_res_hs;

  // Handshakes qualify the external valid/ready with registered readies only.
  assign w_cmd_hs = cmd_valid & r_cmd_ready;
  assign w_op_hs  = op_valid  & r_op_ready;
  assign w_res_hs = r_res_valid & res_ready;

  // Job control FSM with registered handshake outputs and counters.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_drain_cnt <= '0;
      r_first     <= 1'b0;
      r_cfg       <= '0;
      r_cmd_ready <= 1'b0;
      r_op_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_res_z1    <= '0;
      r_res_z2    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_hs) begin
            r_cfg       <= '{shift:      cmd_shift,
                             round:      cmd_round,
                             saturate:   cmd_saturate,
                             subtract:   cmd_subtract,
                             unsigned_a: cmd_unsigned_a,
                             unsigned_b: cmd_unsigned_b};
            r_remaining <= cmd_len;
            r_first     <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_op_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ACCUM;
          end
        end

        ST_ACCUM: begin
          if (w_op_hs) begin
            r_first <= 1'b0;
            if (r_remaining == '0) begin
              r_op_ready  <= 1'b0;
              r_drain_cnt <= DRAIN_INIT;
              r_state     <= ST_DRAIN;
            end else begin
              r_remaining <= r_remaining - 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_res_z1    <= dsp_z1;
            r_res_z2    <= dsp_z2;
            r_res_valid <= 1'b1;
            r_state     <= ST_RESULT;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end

        ST_RESULT: begin
          if (w_res_hs) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand register in front of the DSP; zero on every non-handshake cycle.
  dsp19x2_op_stage u_op_stage (
    .CLK            (CLK),
    .RESET          (RESET),
    .i_load         (w_op_hs),
    .i_first        (r_first),
    .i_a1           (op_a1),
    .i_a2           (op_a2),
    .i_b1           (op_b1),
    .i_b2           (op_b2),
    .o_dsp_a1       (dsp_a1),
    .o_dsp_a2       (dsp_a2),
    .o_dsp_b1       (dsp_b1),
    .o_dsp_b2       (dsp_b2),
    .o_dsp_load_acc (dsp_load_acc)
  );

  assign cmd_ready       = r_cmd_ready;
  assign op_ready        = r_op_ready;
  assign res_valid       = r_res_valid;
  assign busy            = r_busy;
  assign res_z1          = r_res_z1;
  assign res_z2          = r_res_z2;

  assign dsp_feedback    = 3'b000;
  assign dsp_shift_right = r_cfg.shift;
  assign dsp_round       = r_cfg.round;
  assign dsp_saturate    = r_cfg.saturate;
  assign dsp_subtract    = r_cfg.subtract;
  assign dsp_unsigned_a  = r_cfg.unsigned_a;
  assign dsp_unsigned_b  = r_cfg.unsigned_b;

endmodule

// File: tb/tb_dsp19x2_mac_sequencer.sv
// Self-checking bench for dsp19x2_mac_sequencer. A behavioural DSP19X2
// plant (input + output register, wide accumulator, arithmetic shift,
// truncating/wrapping output) closes the loop; expected sums come from a
// plain dot product over the stimulus arrays.
module tb_dsp19x2_mac_sequencer;

  localparam int LEN_W  = 8;
  localparam int TB_LAT = 2;

  logic        CLK;
  logic        RESET;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_len;
  logic [4:0]  cmd_shift;
  logic        cmd_round, cmd_saturate, cmd_subtract, cmd_unsigned_a, cmd_unsigned_b;
  logic        op_valid, op_ready;
  logic [9:0]  op_a1, op_a2;
  logic [8:0]  op_b1, op_b2;
  logic        res_valid, res_ready;
  logic [18:0] res_z1, res_z2;
  logic        busy;
  logic [9:0]  dsp_a1, dsp_a2;
  logic [8:0]  dsp_b1, dsp_b2;
  logic        dsp_load_acc;
  logic [2:0]  dsp_feedback;
  logic [4:0]  dsp_shift_right;
  logic        dsp_round, dsp_saturate, dsp_subtract, dsp_unsigned_a, dsp_unsigned_b;
  logic [18:0] dsp_z1, dsp_z2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Stimulus for the current job.
  logic [9:0] g_a1 [256];
  logic [9:0] g_a2 [256];
  logic [8:0] g_b1 [256];
  logic [8:0] g_b2 [256];
  logic [4:0] g_shift;
  logic       g_round, g_sat, g_sub, g_ua, g_ub;

  dsp19x2_mac_sequencer #(.LEN_W(LEN_W), .DSP_LATENCY(TB_LAT)) dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_shift(cmd_shift), .cmd_round(cmd_round), .cmd_saturate(cmd_saturate),
    .cmd_subtract(cmd_subtract), .cmd_unsigned_a(cmd_unsigned_a), .cmd_unsigned_b(cmd_unsigned_b),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a1(op_a1), .op_a2(op_a2), .op_b1(op_b1), .op_b2(op_b2),
    .res_valid(res_valid), .res_ready(res_ready), .res_z1(res_z1), .res_z2(res_z2),
    .busy(busy),
    .dsp_a1(dsp_a1), .dsp_a2(dsp_a2), .dsp_b1(dsp_b1), .dsp_b2(dsp_b2),
    .dsp_load_acc(dsp_load_acc), .dsp_feedback(dsp_feedback),
    .dsp_shift_right(dsp_shift_right), .dsp_round(dsp_round), .dsp_saturate(dsp_saturate),
    .dsp_subtract(dsp_subtract), .dsp_unsigned_a(dsp_unsigned_a), .dsp_unsigned_b(dsp_unsigned_b),
    .dsp_z1(dsp_z1), .dsp_z2(dsp_z2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Operand product honouring the per-operand signedness flags.
  function automatic longint mul(input logic [9:0] a, input logic [8:0] b,
                                 input logic ua, input logic ub);
    longint sa, sb;
    sa = ua ? longint'({54'd0, a}) : longint'({{54{a[9]}}, a});
    sb = ub ? longint'({55'd0, b}) : longint'({{55{b[8]}}, b});
    return sa * sb;
  endfunction

  // ---------------- behavioural DSP19X2 plant (latency 2) ----------------
  logic [9:0] m_a1, m_a2;
  logic [8:0] m_b1, m_b2;
  logic       m_load = 1'b0;
  longint     m_acc1 = 0;
  longint     m_acc2 = 0;
  longint     m_p1, m_p2, m_t1, m_t2;

  always @(posedge CLK) begin
    m_p1 = mul(m_a1, m_b1, dsp_unsigned_a, dsp_unsigned_b);
    m_p2 = mul(m_a2, m_b2, dsp_unsigned_a, dsp_unsigned_b);
    if (dsp_subtract) begin
      m_p1 = -m_p1;
      m_p2 = -m_p2;
    end
    m_acc1 <= m_load ? m_p1 : m_acc1 + m_p1;
    m_acc2 <= m_load ? m_p2 : m_acc2 + m_p2;
    m_a1   <= dsp_a1;
    m_a2   <= dsp_a2;
    m_b1   <= dsp_b1;
    m_b2   <= dsp_b2;
    m_load <= dsp_load_acc;
  end

  always_comb begin
    m_t1   = m_acc1 >>> dsp_shift_right;
    m_t2   = m_acc2 >>> dsp_shift_right;
    dsp_z1 = m_t1[18:0];
    dsp_z2 = m_t2[18:0];
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_op_ready"},  32'(op_ready),  32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_res_z"},     32'({res_z1[12:0], res_z2}), 32'd0);
    check({tag, "_dsp_ops"},   32'({dsp_a1, dsp_b1, dsp_load_acc}), 32'd0);
    check({tag, "_dsp_ops2"},  32'({dsp_a2, dsp_b2}), 32'd0);
    check({tag, "_dsp_cfg"},   32'({dsp_feedback, dsp_shift_right, dsp_round, dsp_saturate,
                                    dsp_subtract, dsp_unsigned_a, dsp_unsigned_b}), 32'd0);
  endtask

  task automatic set_cfg(input int shift, input bit rnd, input bit sat, input bit sub,
                         input bit ua, input bit ub);
    g_shift = 5'(shift);
    g_round = rnd;
    g_sat   = sat;
    g_sub   = sub;
    g_ua    = ua;
    g_ub    = ub;
  endtask

  task automatic fill(input int n, input int a1, input int b1, input int a2, input int b2);
    for (int i = 0; i < n; i++) begin
      g_a1[i] = 10'(a1);
      g_b1[i] = 9'(b1);
      g_a2[i] = 10'(a2);
      g_b2[i] = 9'(b2);
    end
  endtask

  // One full job: command, operand stream with optional bubbles, optional
  // result backpressure, result handshake.
  task automatic run_job(input int len, input int bubble_pct, input int hold, input string tag);
    longint      s1 = 0;
    longint      s2 = 0;
    longint      r1, r2;
    logic [18:0] e1, e2;
    int          idx = 0;
    int          loads = 0;
    int          cyc = 0;
    int          lat = 1;
    int          budget;

    for (int i = 0; i <= len; i++) begin
      s1 += mul(g_a1[i], g_b1[i], g_ua, g_ub);
      s2 += mul(g_a2[i], g_b2[i], g_ua, g_ub);
    end
    if (g_sub) begin
      s1 = -s1;
      s2 = -s2;
    end
    r1 = s1 >>> g_shift;
    r2 = s2 >>> g_shift;
    e1 = r1[18:0];
    e2 = r2[18:0];
    budget = (len + 1) * 20 + 50;

    cmd_len        = 8'(len);
    cmd_shift      = g_shift;
    cmd_round      = g_round;
    cmd_saturate   = g_sat;
    cmd_subtract   = g_sub;
    cmd_unsigned_a = g_ua;
    cmd_unsigned_b = g_ub;
    cmd_valid      = 1'b1;
    while (!cmd_ready && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    check({tag, "_op_ready_open"}, 32'(op_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cmd_ready_low"}, 32'(cmd_ready), 32'd0);
    check({tag, "_cfg"},
          32'({dsp_shift_right, dsp_round, dsp_saturate, dsp_subtract, dsp_unsigned_a, dsp_unsigned_b}),
          32'({g_shift, g_round, g_sat, g_sub, g_ua, g_ub}));

    cyc = 0;
    while (idx <= len && cyc < budget) begin
      op_valid = ($urandom_range(0, 99) >= bubble_pct);
      op_a1    = g_a1[idx];
      op_b1    = g_b1[idx];
      op_a2    = g_a2[idx];
      op_b2    = g_b2[idx];
      if (dsp_load_acc) loads++;
      if (op_valid && op_ready) idx++;
      @(negedge CLK);
      cyc++;
    end
    op_valid = 1'b0;
    check({tag, "_pairs_accepted"}, 32'(idx), 32'(len + 1));
    check({tag, "_op_ready_closed"}, 32'(op_ready), 32'd0);

    while (!res_valid && lat < 40) begin
      if (dsp_load_acc) loads++;
      @(negedge CLK);
      lat++;
    end
    check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(2 + TB_LAT));
    check({tag, "_load_acc_count"}, 32'(loads), 32'd1);

    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_z1"}, 32'(res_z1), 32'(e1));
      check({tag, "_hold_z2"}, 32'(res_z2), 32'(e2));
      check({tag, "_hold_ready"}, 32'({res_valid, op_ready, cmd_ready}), 32'b100);
      @(negedge CLK);
    end
    check({tag, "_z1"}, 32'(res_z1), 32'(e1));
    check({tag, "_z2"}, 32'(res_z2), 32'(e2));

    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    check({tag, "_res_done"}, 32'({res_valid, busy, cmd_ready}), 32'b001);
  endtask

  // ---------------- directed + random sequence ----------------
  int hs;
  int rlen;
  bit seen_rv;

  initial begin
    RESET     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_shift = '0;
    {cmd_round, cmd_saturate, cmd_subtract, cmd_unsigned_a, cmd_unsigned_b} = '0;
    op_valid  = 1'b0;
    {op_a1, op_a2, op_b1, op_b2} = '0;
    res_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RESET = 1'b1;
    @(negedge CLK);
    check("reset_release_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single signed pair: 3*4 = 12, -2*5 = -10.
    set_cfg(0, 0, 0, 0, 0, 0);
    fill(1, 3, 4, -2, 5);
    run_job(0, 0, 0, "single");

    // Four pairs (2,3) with random op_valid bubbles -> 24 on both lanes.
    fill(4, 2, 3, 2, 3);
    run_job(3, 50, 0, "bubbles");

    // Back-to-back jobs with result backpressure on the first: 3 then 25.
    fill(3, 1, 1, 1, 1);
    run_job(2, 0, 10, "b2b_sum3");
    fill(1, 5, 5, 5, 5);
    run_job(0, 0, 0, "b2b_sum25");

    // Reset after 2 of 4 pairs: job aborted, no result.
    fill(4, 1, 1, 1, 1);
    cmd_len   = 8'd3;
    cmd_valid = 1'b1;
    hs = 0;
    for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    op_valid  = 1'b1;
    op_a1 = 10'd1; op_b1 = 9'd1; op_a2 = 10'd1; op_b2 = 9'd1;
    for (int k = 0; k < 50 && hs < 2; k++) begin
      if (op_valid && op_ready) hs++;
      @(negedge CLK);
    end
    check("midrst_two_pairs", 32'(hs), 32'd2);
    op_valid = 1'b0;
    RESET    = 1'b0;
    @(negedge CLK);
    check_all_zero("midrst");
    RESET = 1'b1;
    @(negedge CLK);
    check("midrst_release_cmd_ready", 32'(cmd_ready), 32'd1);
    seen_rv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      seen_rv |= res_valid;
      @(negedge CLK);
    end
    check("midrst_no_result", 32'(seen_rv), 32'd0);
    fill(1, 7, -1, 7, -1);
    run_job(0, 0, 0, "after_reset");

    // Maximum length: 256 pairs of (1,1) -> 256.
    fill(256, 1, 1, 1, 1);
    run_job(255, 0, 0, "maxlen");

    // Random jobs: random lengths, operands, shift, signedness, subtract,
    // bubbles and backpressure. The plant truncates and wraps, so round and
    // saturate are exercised as configuration pass-through.
    for (int j = 0; j < 8; j++) begin
      rlen = $urandom_range(0, 15);
      set_cfg($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i <= rlen; i++) begin
        g_a1[i] = 10'($urandom);
        g_b1[i] = 9'($urandom);
        g_a2[i] = 10'($urandom);
        g_b2[i] = 9'($urandom);
      end
      run_job(rlen, 30, $urandom_range(0, 3), $sformatf("rand%0d", j));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
